// File: rtl/k580vv55_arb_if.sv
// Requester and PPI-side signal bundle for the k580vv55 access arbiter.
// slave is the arbiter's view; master is the requester/PPI-model view.
interface k580vv55_arb_if;
    logic       cpu_req;
    logic       cpu_wr;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;

    logic       kbd_req;
    logic       kbd_wr;
    logic [1:0] kbd_addr;
    logic [7:0] kbd_wdata;
    logic       kbd_ack;
    logic [7:0] kbd_rdata;

    logic [1:0] ppi_addr;
    logic [7:0] ppi_idata;
    logic       ppi_we_n;
    logic [7:0] ppi_odata;
    logic       busy;
    logic       owner;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  kbd_req, kbd_wr, kbd_addr, kbd_wdata,
        input  ppi_odata,
        output cpu_ack, cpu_rdata, kbd_ack, kbd_rdata,
        output ppi_addr, ppi_idata, ppi_we_n, busy, owner
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output kbd_req, kbd_wr, kbd_addr, kbd_wdata,
        output ppi_odata,
        input  cpu_ack, cpu_rdata, kbd_ack, kbd_rdata,
        input  ppi_addr, ppi_idata, ppi_we_n, busy, owner
    );
endinterface

// File: rtl/k580vv55_arb.sv
// Two-way round-robin arbiter and access sequencer for the k580vv55 PPI:
// setup, multi-cycle active-low write strobe, hold, and timed read sampling.
module k580vv55_arb #(
    parameter int unsigned STROBE_LEN = 2,
    parameter int unsigned READ_WAIT  = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    k580vv55_arb_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, HOLD, RWAIT, DONE
    } state_t;

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_LEN - 1);
    localparam logic [3:0] READ_LOAD   = 4'(READ_WAIT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wr_q, wr_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] idata_q, idata_d;
    logic       we_n_q, we_n_d;
    logic       cpu_ack_q, cpu_ack_d;
    logic       kbd_ack_q, kbd_ack_d;
    logic [7:0] cpu_rdata_q, cpu_rdata_d;
    logic [7:0] kbd_rdata_q, kbd_rdata_d;
    logic       busy_q, busy_d;
    logic       owner_q, owner_d;
    logic       grant_kbd;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        idata_d     = idata_q;
        owner_d     = owner_q;
        cpu_rdata_d = cpu_rdata_q;
        kbd_rdata_d = kbd_rdata_q;
        // On contention the requester that was not served last wins.
        grant_kbd   = bus.kbd_req & (~bus.cpu_req | ~owner_q);

        case (state_q)
            IDLE: begin
                if (bus.cpu_req | bus.kbd_req) begin
                    owner_d = grant_kbd;
                    wr_d    = grant_kbd ? bus.kbd_wr    : bus.cpu_wr;
                    addr_d  = grant_kbd ? bus.kbd_addr  : bus.cpu_addr;
                    idata_d = grant_kbd ? bus.kbd_wdata : bus.cpu_wdata;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (wr_q) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LOAD;
                end else begin
                    state_d = RWAIT;
                    cnt_d   = READ_LOAD;
                end
            end
            STROBE: begin
                if (cnt_q == '0) state_d = HOLD;
                else             cnt_d   = cnt_q - 4'd1;
            end
            HOLD: state_d = DONE;
            RWAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (owner_q) kbd_rdata_d = bus.ppi_odata;
                    else         cpu_rdata_d = bus.ppi_odata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobe, busy and acks are decoded from the next state so they leave a flop.
        we_n_d    = (state_d != STROBE);
        busy_d    = (state_d != IDLE);
        cpu_ack_d = (state_d == DONE) & ~owner_q;
        kbd_ack_d = (state_d == DONE) &  owner_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            idata_q     <= '0;
            we_n_q      <= 1'b1;
            cpu_ack_q   <= 1'b0;
            kbd_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            kbd_rdata_q <= '0;
            busy_q      <= 1'b0;
            owner_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            idata_q     <= idata_d;
            we_n_q      <= we_n_d;
            cpu_ack_q   <= cpu_ack_d;
            kbd_ack_q   <= kbd_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            kbd_rdata_q <= kbd_rdata_d;
            busy_q      <= busy_d;
            owner_q     <= owner_d;
        end
    end

    assign bus.ppi_addr  = addr_q;
    assign bus.ppi_idata = idata_q;
    assign bus.ppi_we_n  = we_n_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.kbd_ack   = kbd_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.kbd_rdata = kbd_rdata_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_k580vv55_arb.sv
// Bench for k580vv55_arb: default-parameter instance plus a STROBE_LEN=1/READ_WAIT=4
// instance, with an ack scoreboard and per-cycle PPI waveform checks.
module tb_k580vv55_arb;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always_ff @(posedge clk) cyc <= cyc + 1;

    k580vv55_arb_if ifa ();
    k580vv55_arb_if ifb ();

    k580vv55_arb dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
    k580vv55_arb #(.STROBE_LEN(1), .READ_WAIT(4)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

    // Stimulus, index 0 = CPU, 1 = KBD; dsel picks which instance sees it.
    logic       dsel = 1'b0;
    logic       req [2];
    logic       wr  [2];
    logic [1:0] adr [2];
    logic [7:0] wd  [2];
    logic [7:0] odata_tab [4];

    assign ifa.cpu_req   = req[0] & ~dsel;
    assign ifa.kbd_req   = req[1] & ~dsel;
    assign ifb.cpu_req   = req[0] & dsel;
    assign ifb.kbd_req   = req[1] & dsel;
    assign ifa.cpu_wr    = wr[0];
    assign ifa.kbd_wr    = wr[1];
    assign ifb.cpu_wr    = wr[0];
    assign ifb.kbd_wr    = wr[1];
    assign ifa.cpu_addr  = adr[0];
    assign ifa.kbd_addr  = adr[1];
    assign ifb.cpu_addr  = adr[0];
    assign ifb.kbd_addr  = adr[1];
    assign ifa.cpu_wdata = wd[0];
    assign ifa.kbd_wdata = wd[1];
    assign ifb.cpu_wdata = wd[0];
    assign ifb.kbd_wdata = wd[1];
    assign ifa.ppi_odata = odata_tab[ifa.ppi_addr];
    assign ifb.ppi_odata = odata_tab[ifb.ppi_addr];

    logic       o_we_n, o_busy, o_owner, o_cpu_ack, o_kbd_ack;
    logic [1:0] o_addr;
    logic [7:0] o_idata, o_cpu_rdata, o_kbd_rdata;
    assign o_we_n      = dsel ? ifb.ppi_we_n  : ifa.ppi_we_n;
    assign o_busy      = dsel ? ifb.busy      : ifa.busy;
    assign o_owner     = dsel ? ifb.owner     : ifa.owner;
    assign o_cpu_ack   = dsel ? ifb.cpu_ack   : ifa.cpu_ack;
    assign o_kbd_ack   = dsel ? ifb.kbd_ack   : ifa.kbd_ack;
    assign o_addr      = dsel ? ifb.ppi_addr  : ifa.ppi_addr;
    assign o_idata     = dsel ? ifb.ppi_idata : ifa.ppi_idata;
    assign o_cpu_rdata = dsel ? ifb.cpu_rdata : ifa.cpu_rdata;
    assign o_kbd_rdata = dsel ? ifb.kbd_rdata : ifa.kbd_rdata;

    typedef struct {
        bit         who;
        bit         wr;
        int         cyc;
        logic [7:0] rdata;
    } rec_t;
    rec_t       sb [$];
    logic [7:0] exp_rd [2][2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
        end
    endtask

    // Entered just after a rising edge; the grant is sampled at the end of this cycle.
    task automatic do_txn(input bit who, input bit w, input logic [1:0] a, input logic [7:0] d,
                          input int sl, input int rw, input int late_n, input logic [7:0] late_val);
        int   g, n, ackn;
        bit   done;
        rec_t r;
        logic got_ack, oth_ack;
        wr[who]  = w;
        adr[who] = a;
        wd[who]  = d;
        req[who] = 1'b1;
        g    = cyc;
        ackn = w ? 3 + sl : 2 + rw;
        r.who   = who;
        r.wr    = w;
        r.cyc   = g + ackn;
        r.rdata = (late_n != 0) ? late_val : odata_tab[a];
        sb.push_back(r);
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            n = cyc - g;
            if (late_n != 0 && n == late_n) odata_tab[a] = late_val;
            @(negedge clk);
            got_ack = who ? o_kbd_ack : o_cpu_ack;
            oth_ack = who ? o_cpu_ack : o_kbd_ack;
            check("we_n", o_we_n, !(w && n >= 2 && n <= 1 + sl));
            check("busy", o_busy, n >= 1);
            check("ack_timing", got_ack, n == ackn);
            check("other_ack", oth_ack, 0);
            if (n >= 1) begin
                check("ppi_addr", o_addr, a);
                check("ppi_idata", o_idata, d);
                check("owner", o_owner, who);
            end
            if (got_ack) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) check("ack_timeout", 0, 1);
        req[who] = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   g;
        rec_t r;
        for (int unsigned i = 0; i < 2; i++) begin
            req[i] = 1'b0;
            wr[i]  = 1'b0;
            adr[i] = '0;
            wd[i]  = '0;
        end
        for (int unsigned i = 0; i < 4; i++) odata_tab[i] = '0;

        fork
            forever begin
                @(negedge clk or negedge reset_n);
                if (!reset_n) begin
                    sb.delete();
                    for (int unsigned i = 0; i < 2; i++)
                        for (int unsigned j = 0; j < 2; j++) exp_rd[i][j] = '0;
                end else if (o_cpu_ack | o_kbd_ack) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected_ack", 1, 0);
                    end else begin
                        r = sb.pop_front();
                        check("sb_ack_who", o_kbd_ack, r.who);
                        check("sb_ack_both", o_cpu_ack & o_kbd_ack, 0);
                        check("sb_ack_cycle", cyc, r.cyc);
                        if (!r.wr) exp_rd[dsel][r.who] = r.rdata;
                        check("sb_cpu_rdata", o_cpu_rdata, exp_rd[dsel][0]);
                        check("sb_kbd_rdata", o_kbd_rdata, exp_rd[dsel][1]);
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_we_n", o_we_n, 1);
        check("rst_addr", o_addr, 0);
        check("rst_idata", o_idata, 0);
        check("rst_cpu_ack", o_cpu_ack, 0);
        check("rst_kbd_ack", o_kbd_ack, 0);
        check("rst_cpu_rdata", o_cpu_rdata, 0);
        check("rst_kbd_rdata", o_kbd_rdata, 0);
        check("rst_busy", o_busy, 0);
        check("rst_owner", o_owner, 1);
        @(posedge clk);
        #1;

        // Basic CPU write then CPU read; KBD read data must stay untouched.
        do_txn(0, 1, 2'd3, 8'h82, 2, 1, 0, 8'h00);
        @(posedge clk);
        #1;
        odata_tab[1] = 8'h5A;
        do_txn(0, 0, 2'd1, 8'h00, 2, 1, 0, 8'h00);
        @(posedge clk);
        #1;

        // Reset mid-strobe forces we_n high and clears busy/acks without a clock.
        wr[0] = 1'b1; adr[0] = 2'd2; wd[0] = 8'hE7; req[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_in_strobe", o_we_n, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_we_n", o_we_n, 1);
        check("abort_busy", o_busy, 0);
        check("abort_cpu_ack", o_cpu_ack, 0);
        check("abort_kbd_ack", o_kbd_ack, 0);
        check("abort_addr", o_addr, 0);
        req[0] = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        do_txn(0, 1, 2'd0, 8'h55, 2, 1, 0, 8'h00);

        // Both requesters held together after reset: CPU, KBD, CPU, KBD.
        pulse_reset();
        odata_tab[1] = 8'hC3;
        odata_tab[2] = 8'h4B;
        wr[0] = 1'b0; adr[0] = 2'd1; wd[0] = 8'h10;
        wr[1] = 1'b0; adr[1] = 2'd2; wd[1] = 8'h20;
        req[0] = 1'b1;
        req[1] = 1'b1;
        g = cyc;
        for (int unsigned i = 0; i < 4; i++) begin
            r.who   = i[0];
            r.wr    = 1'b0;
            r.cyc   = g + 3 + 4 * int'(i);
            r.rdata = i[0] ? 8'h4B : 8'hC3;
            sb.push_back(r);
        end
        @(negedge clk);
        @(negedge clk);
        check("rr_first_owner", o_owner, 0);
        repeat (15) @(posedge clk);
        #1;
        req[0] = 1'b0;
        req[1] = 1'b0;
        check("rr_sb_drained", sb.size(), 0);
        @(posedge clk);
        #1;

        // KBD write with a CPU request arriving mid-strobe; CPU served right after.
        fork
            do_txn(1, 1, 2'd0, 8'h3C, 2, 1, 0, 8'h00);
            begin
                repeat (2) @(posedge clk);
                #2;
                wr[0] = 1'b1; adr[0] = 2'd2; wd[0] = 8'h99; req[0] = 1'b1;
            end
        join
        do_txn(0, 1, 2'd2, 8'h99, 2, 1, 0, 8'h00);
        @(posedge clk);
        #1;

        // Port 3 read returns whatever the PPI drives.
        odata_tab[3] = 8'h00;
        do_txn(1, 0, 2'd3, 8'h00, 2, 1, 0, 8'h00);
        @(posedge clk);
        #1;

        // Short-strobe / long-read instance; read data changes on the 3rd wait cycle.
        dsel = 1'b1;
        @(posedge clk);
        #1;
        do_txn(0, 1, 2'd2, 8'hA5, 1, 4, 0, 8'h00);
        @(posedge clk);
        #1;
        odata_tab[1] = 8'h11;
        do_txn(0, 0, 2'd1, 8'h00, 1, 4, 4, 8'h77);
        @(posedge clk);
        #1;
        do_txn(1, 0, 2'd1, 8'h00, 1, 4, 0, 8'h00);
        repeat (2) @(posedge clk);
        #1;

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/k580vv55_arb.md
Name: k580vv55_arb

Overview:
- Synchronous access sequencer and two-way arbiter in front of the k580vv55 parallel interface.
- Shares the one PPI between two requesters: the CPU I/O port decoder (CPU) and the hardware keyboard scanner (KBD).
- Converts single-clock req/ack transactions into a correctly timed PPI access: address/data setup, a multi-cycle active-low write strobe, hold, and a sampled read.

Parameters:
- STROBE_LEN, 2, number of clk cycles ppi_we_n is held low per write; legal range 1..15.
- READ_WAIT, 1, number of clk cycles between address setup and read sampling; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU request; held high with fields stable until cpu_ack.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_addr  in  2  PPI register address.
- cpu_wdata  in  8  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read result; valid in the cpu_ack cycle and held until the next CPU read completes.
- kbd_req, kbd_wr, kbd_addr, kbd_wdata, kbd_ack, kbd_rdata: same as the cpu_* ports, for KBD.
- ppi_addr  out  2  to PPI addr.
- ppi_idata  out  8  to PPI idata.
- ppi_we_n  out  1  to PPI we_n; the PPI latches on its falling edge.
- ppi_odata  in  8  from PPI odata (combinational).
- busy  out  1  high in every state except IDLE.
- owner  out  1  0 = CPU, 1 = KBD; the requester of the current or last transaction.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; ppi_we_n=1 immediately.
  - ppi_addr=0, ppi_idata=0, cpu_ack=kbd_ack=0, cpu_rdata=kbd_rdata=0, busy=0.
  - owner=1, so the CPU wins the first contention.
  - A write aborted mid-strobe returns ppi_we_n high without a further falling edge. The PPI may already have latched the write; this is acceptable.
- States: IDLE, SETUP, STROBE, HOLD, RWAIT, DONE.
- IDLE arbitration:
  - Only one req high: grant that requester.
  - Both high: grant the requester that is not the current owner (round robin).
  - On grant: register wr, addr, wdata into ppi_addr/ppi_idata and an internal wr flag; set owner; go to SETUP.
- SETUP (1 cycle): ppi_we_n=1, address/data stable. Next state: STROBE if write, RWAIT if read.
- STROBE: ppi_we_n=0 for exactly STROBE_LEN cycles (down-counter), then HOLD.
- HOLD (1 cycle): ppi_we_n=1, address/data unchanged, then DONE.
- RWAIT: READ_WAIT cycles. On the last cycle, capture ppi_odata into the owner's rdata register, then DONE.
- DONE (1 cycle): owner's ack=1; the other ack stays 0. Next state IDLE.
- Timing, grant sampled at cycle 0:
  - Write: ack at cycle 3+STROBE_LEN (defaults: cycle 5).
  - Read: ack at cycle 2+READ_WAIT (defaults: cycle 3).
- ppi_addr/ppi_idata change only on grant. They are held through DONE and IDLE, so no spurious PPI address glitch occurs while ppi_we_n=1.
- Requester protocol:
  - req must drop in the cycle after ack. A req still high in the IDLE cycle after DONE is a new transaction.
  - Minimum spacing between back-to-back transactions is one IDLE cycle.
  - A non-owner request raised during a transaction waits; it is not dropped.
- cpu_rdata is never modified by KBD reads, and vice versa.
- Port 3 reads return whatever ppi_odata presents (0 for the PPI); no special casing.
- Counters are 4 bits wide. A STROBE_LEN or READ_WAIT outside 1..15 is illegal and must not be instantiated.

Test Plan:
- Reset then CPU write, addr=3, wdata=0x82 → ppi_we_n low for exactly cycles 2–3 after grant, ppi_addr=3 and ppi_idata=0x82 from cycle 1 through 4, single cpu_ack at cycle 5, busy high cycles 1–5.
- CPU read addr=1 with ppi_odata=0x5A → ppi_we_n never low, cpu_ack at cycle 3, cpu_rdata=0x5A, kbd_rdata remains 0x00.
- cpu_req and kbd_req raised together after reset → CPU served first (owner=0), KBD granted in the IDLE cycle after cpu_ack. With both held continuously the grants alternate CPU, KBD, CPU, KBD.
- KBD write in progress, CPU raises req mid-strobe → KBD's strobe length and data are unaffected, kbd_ack fires, and the CPU is granted next with no lost request.
- reset_n asserted during STROBE (ppi_we_n=0) → ppi_we_n=1, busy=0 and both acks 0 asynchronously. After release, a fresh CPU write completes with normal timing.
- Parameter sweep STROBE_LEN=1/READ_WAIT=4 → write ack at cycle 4 with a 1-cycle strobe, read ack at cycle 6 sampling ppi_odata on the 4th wait cycle (ppi_odata changed on wait cycle 3 must be captured).
